// File: rtl/conta_down_mn_ers.sv
// Modulo-MOD down counter with load, wrap/one-shot modes and cascade tc.
// State machine IDLE -> RUN -> EXPIRED; all outputs registered except tc.
module conta_down_mn_ers #(
    parameter int MOD = 5,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         oneshot,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         borrow,
    output logic         expired,
    output logic         busy
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] load_d;
    logic         borrow_q;
    logic         busy_q;
    logic         expired_q;
    logic         at_zero;

    assign at_zero = (cnt_q == '0);

    // Clamp the load value so the count never leaves 0..MOD-1.
    always_comb begin
        load_d = d;
        if (d > TOP) begin
            load_d = TOP;
        end
    end

    // State, count and registered flags; reset > load > enable > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else if (load) begin
            state_q   <= RUN;
            cnt_q     <= load_d;
            borrow_q  <= 1'b0;
            busy_q    <= 1'b1;
            expired_q <= 1'b0;
        end else begin
            borrow_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (enable) begin
                        if (!at_zero) begin
                            cnt_q <= cnt_q - W'(1);
                        end else if (!oneshot) begin
                            cnt_q    <= TOP;
                            borrow_q <= 1'b1;
                        end else begin
                            state_q   <= EXPIRED;
                            busy_q    <= 1'b0;
                            expired_q <= 1'b1;
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign q       = cnt_q;
    assign borrow  = borrow_q;
    assign busy    = busy_q;
    assign expired = expired_q;
    assign tc      = enable & at_zero & (state_q == RUN);

endmodule

// File: tb/tb_conta_down_mn_ers.sv
// Bench for conta_down_mn_ers: directed vector table, then random
// stimulus against a rule-level reference model (MOD=5, W=3).
module tb_conta_down_mn_ers;

    localparam int MOD = 5;
    localparam int W   = 3;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         load;
    logic [W-1:0] d;
    logic         oneshot;
    logic [W-1:0] q;
    logic         tc;
    logic         borrow;
    logic         expired;
    logic         busy;

    int tests = 0;
    int fails = 0;

    // model: state 0=IDLE 1=RUN 2=EXPIRED
    int mq  = 0;
    int mst = 0;
    int mbo = 0;

    typedef struct {
        int rst; int ld; int en; int os; int dv;
        int tc;  int q;  int bo; int bz; int ex;
    } vec_t;

    vec_t tbl[$];

    conta_down_mn_ers #(.MOD(MOD), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .d       (d),
        .oneshot (oneshot),
        .q       (q),
        .tc      (tc),
        .borrow  (borrow),
        .expired (expired),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int r, input int l, input int e, input int o, input int dv);
        @(negedge clk);
        reset   = r[0];
        load    = l[0];
        enable  = e[0];
        oneshot = o[0];
        d       = 3'(dv);
        #1;
    endtask

    // Reference model: one edge computed straight from the counter rules.
    task automatic model_edge(input int r, input int l, input int e, input int o, input int dv);
        mbo = 0;
        if (r != 0) begin
            mq = 0; mst = 0;
        end else if (l != 0) begin
            mq  = (dv > MOD - 1) ? MOD - 1 : dv;
            mst = 1;
        end else if (mst == 1 && e != 0) begin
            if (mq > 0) mq = mq - 1;
            else if (o == 0) begin
                mq = MOD - 1; mbo = 1;
            end else mst = 2;
        end
    endtask

    // One model-checked cycle: tc before the edge, registered outputs after.
    task automatic cyc(input int r, input int l, input int e, input int o, input int dv, input int idx);
        int mtc;
        drive(r, l, e, o, dv);
        mtc = (e != 0 && mq == 0 && mst == 1) ? 1 : 0;
        chk("rnd_tc", idx, int'(tc), mtc);
        @(posedge clk);
        model_edge(r, l, e, o, dv);
        #1;
        chk("rnd_q", idx, int'(q), mq);
        chk("rnd_flags", idx, {int'(borrow), int'(busy), int'(expired)},
            {mbo, int'(mst == 1), int'(mst == 2)});
        if (int'(q) > MOD - 1) begin
            tests++; fails++;
            $display("FAIL q_range [%0d]: got %0d expected <= %0d", idx, q, MOD - 1);
        end
    endtask

    initial begin
        int e_cnt;
        int b_cnt;
        int q0;
        vec_t v;

        reset = 1'b0; load = 1'b0; enable = 1'b0; oneshot = 1'b0; d = '0;

        // rst ld en os d | tc q bo busy exp   (tc sampled before the edge)
        tbl.push_back('{0,0,1,0,0, 0,0,0,0,0});
        tbl.push_back('{0,1,0,0,3, 0,3,0,1,0});
        tbl.push_back('{0,0,1,0,0, 0,2,0,1,0});
        tbl.push_back('{0,0,1,0,0, 0,1,0,1,0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,1,0});
        tbl.push_back('{0,0,1,0,0, 1,4,1,1,0});
        tbl.push_back('{0,0,1,0,0, 0,3,0,1,0});
        tbl.push_back('{0,0,0,0,0, 0,3,0,1,0});
        tbl.push_back('{0,1,0,1,2, 0,2,0,1,0});
        tbl.push_back('{0,0,1,1,0, 0,1,0,1,0});
        tbl.push_back('{0,0,1,1,0, 0,0,0,1,0});
        tbl.push_back('{0,0,1,1,0, 1,0,0,0,1});
        tbl.push_back('{0,0,1,1,0, 0,0,0,0,1});
        tbl.push_back('{0,0,1,0,0, 0,0,0,0,1});
        tbl.push_back('{0,1,0,0,7, 0,4,0,1,0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,1,0});
        tbl.push_back('{0,0,1,0,0, 1,4,1,1,0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,1,0});
        tbl.push_back('{0,1,1,0,2, 1,2,0,1,0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,1,0});
        tbl.push_back('{1,0,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,0,0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,1,0});
        tbl.push_back('{0,0,1,0,0, 1,4,1,1,0});
        tbl.push_back('{1,0,1,0,0, 0,0,0,0,0});
        tbl.push_back('{0,1,0,0,3, 0,3,0,1,0});
        tbl.push_back('{1,1,1,0,2, 0,0,0,0,0});

        // Reset state
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("reset_q", 0, int'(q), 0);
        chk("reset_flags", 0, {int'(borrow), int'(busy), int'(expired)}, 0);

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.rst, v.ld, v.en, v.os, v.dv);
            chk("vec_tc", i, int'(tc), v.tc);
            @(posedge clk); #1;
            chk("vec_q", i, int'(q), v.q);
            chk("vec_borrow", i, int'(borrow), v.bo);
            chk("vec_busy", i, int'(busy), v.bz);
            chk("vec_expired", i, int'(expired), v.ex);
        end

        // Wrap-mode random enable: borrow count follows the modulo rule.
        q0 = $urandom_range(0, MOD - 1);
        cyc(1, 0, 0, 0, 0, 1000);
        cyc(0, 1, 0, 0, q0, 1001);
        e_cnt = 0;
        b_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            int en;
            en = int'($urandom_range(0, 1));
            cyc(0, 0, en, 0, 0, 2000 + k);
            e_cnt += en;
            b_cnt += int'(borrow);
        end
        chk("borrow_count", q0, b_cnt, (e_cnt + MOD - 1 - q0) / MOD);

        // Mixed random: loads, resets, mode changes, out-of-range d.
        for (int k = 0; k < 400; k++) begin
            int r;
            int l;
            r = ($urandom_range(0, 29) == 0) ? 1 : 0;
            l = ($urandom_range(0, 6) == 0) ? 1 : 0;
            cyc(r, l, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), 3000 + k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conta_down_mn_ers.md
CONTA_DOWN_MN_ERS -- requirements
Module: conta_down_mn_ers

Interface
REQ-001 Parameter MOD, default 5: counter modulus; legal range 2..2**W.
REQ-002 Parameter W, default 3: counter width in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  count-down request, sampled each rising edge.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 d  input  W  load value.
REQ-008 oneshot  input  1  0 = wrap mode, 1 = one-shot mode; sampled every edge.
REQ-009 q  output  W  current count, registered.
REQ-010 tc  output  1  terminal count, combinational: enable AND (q == 0) AND state RUN; cascade input for next stage.
REQ-011 borrow  output  1  registered one-cycle pulse on wrap.
REQ-012 expired  output  1  registered; high while state is EXPIRED.
REQ-013 busy  output  1  registered; high while state is RUN.

Function
REQ-014 Three states: IDLE, RUN, EXPIRED; encoding is free.
REQ-015 Edge priority, highest first: reset > load > enable > hold.
REQ-016 Load from any state: q <= d when d <= MOD-1, else q <= MOD-1 (clamp); next state RUN; borrow <= 0.
REQ-017 IDLE: enable ignored; q holds; leaves only via load.
REQ-018 RUN, enable=0: q, state and flags hold; borrow <= 0.
REQ-019 RUN, enable=1, q > 0: q <= q-1; borrow <= 0.
REQ-020 RUN, enable=1, q == 0, oneshot=0: q <= MOD-1; borrow <= 1 for exactly one cycle; state stays RUN.
REQ-021 RUN, enable=1, q == 0, oneshot=1: q holds 0; state <= EXPIRED; borrow <= 0.
REQ-022 EXPIRED: enable ignored; q holds 0; leaves only via load (to RUN) or reset (to IDLE).
REQ-023 Borrow never stays high for two consecutive cycles unless a wrap occurs on each of those two edges; at MOD=2 with enable held high, wraps occur on alternate edges only.
REQ-024 Load and enable high on the same edge: load wins; no decrement and no borrow on that edge.
REQ-025 Load with d == 0 enters RUN at q=0; the next enabled edge wraps or expires per oneshot.
REQ-026 All arithmetic is modulo MOD within W bits; q never exceeds MOD-1.
REQ-027 Latency: q, borrow, busy and expired reflect an edge's inputs immediately after that edge; tc follows q and enable combinationally.

Reset
REQ-028 On reset edge: q=0, state=IDLE, borrow=0, expired=0, busy=0.
REQ-029 Reset mid-count or mid-pulse: overrides load and enable; pending borrow is cleared on that edge.
REQ-030 No asynchronous reset path; reset has no effect between clock edges.

Verification (MOD=5, W=3)
REQ-031 Reset, load d=3, enable=1, oneshot=0 -> q: 3,2,1,0,4,3; borrow high only on the cycle q=4; tc high only while q=0.
REQ-032 Load d=2, enable=1, oneshot=1 -> q: 2,1,0 then holds 0; expired=1, busy=0; further enable produces no change.
REQ-033 Load d=7 -> q=4 (clamp); load d=0 followed by enable in wrap mode -> q=4 with borrow pulse.
REQ-034 q=0 in RUN with load=1, d=2 and enable=1 on the same edge -> q=2, borrow=0, state RUN.
REQ-035 Reset asserted on the edge that would wrap from q=0 -> q=0, borrow=0, busy=0; subsequent enable is ignored (IDLE).
REQ-036 Enable toggled randomly for 200 cycles in wrap mode -> number of borrow pulses equals floor((enabled edges + MOD-1-q0)/MOD), where q0 is the loaded value; q is always <= 4.
